// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and helpers for the output-stationary systolic
// matrix multiplier (systolic_mm_core and systolic_pe).
//   state_t     : control FSM states
//   CNT_W       : feed-counter width for the default N=4 array
//   cnt_width() : feed-counter width for an arbitrary N
//   skew_idx()  : operand index presented on an edge lane at feed step t
//   idx_valid() : true when a skewed index addresses a real matrix element
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        FLUSH,
        DONE
    } state_t;

    localparam int unsigned DEF_N = 4;
    localparam int unsigned CNT_W = $clog2(3 * DEF_N);

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(3 * n);
    endfunction

    // Lane r (row for A, column for B) sees element index t - r at step t.
    function automatic int skew_idx(input int unsigned t, input int unsigned lane);
        return int'(t) - int'(lane);
    endfunction

    function automatic logic idx_valid(input int idx, input int unsigned n);
        return (idx >= 0) && (idx < int'(n));
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// systolic_pe: one multiply-accumulate cell of the systolic array.
// Build option: SYSTOLIC_SIGNED_EN selects two's-complement operands;
// otherwise operands are unsigned and zero-extended.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear of accumulator and pass-through registers
//   en_i          : accumulate and shift enable
//   a_i, b_i      : operands arriving from the left / from above
//   a_o, b_o      : registered operands forwarded right / down
//   acc_o         : accumulator, wraps modulo 2^ACC_W
module systolic_pe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 2 * DATA_W + 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);

    localparam int unsigned PW = 2 * DATA_W;

    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod;
    logic [ACC_W-1:0] prod_ext;

    // Operands are widened before the multiply so the low PW bits of the
    // product are exact for both signed and unsigned interpretations.
    always_comb begin
`ifdef SYSTOLIC_SIGNED_EN
        a_ext    = {{DATA_W{a_i[DATA_W-1]}}, a_i};
        b_ext    = {{DATA_W{b_i[DATA_W-1]}}, b_i};
        prod     = a_ext * b_ext;
        prod_ext = ACC_W'($signed(prod));
`else
        a_ext    = {{DATA_W{1'b0}}, a_i};
        b_ext    = {{DATA_W{1'b0}}, b_i};
        prod     = a_ext * b_ext;
        prod_ext = ACC_W'(prod);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_o <= '0;
            a_o   <= '0;
            b_o   <= '0;
        end else if (clr_i) begin
            acc_o <= '0;
            a_o   <= '0;
            b_o   <= '0;
        end else if (en_i) begin
            acc_o <= acc_o + prod_ext;
            a_o   <= a_i;
            b_o   <= b_i;
        end
    end

endmodule

// File: rtl/systolic_mm_core.sv
// systolic_mm_core: NxN output-stationary systolic matrix multiplier, C = A x B.
// Operands are latched on an accepted start and skewed on-chip; the result
// matrix is presented with a one-cycle done pulse 3N edges after acceptance.
// Build option: SYSTOLIC_SIGNED_EN selects two's-complement arithmetic.
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   start_i : request, accepted only in IDLE
//   a_i     : A, element (r,k) at [(r*N+k)*DATA_W +: DATA_W]
//   b_i     : B, element (k,c) at [(k*N+c)*DATA_W +: DATA_W]
//   busy_o  : high from acceptance until done_o
//   done_o  : one-cycle pulse, res_o valid
//   res_o   : C, element (r,c) at [(r*N+c)*ACC_W +: ACC_W], held until next done
module systolic_mm_core
    import systolic_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 2 * DATA_W + $clog2(N)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [N*N*DATA_W-1:0] a_i,
    input  logic [N*N*DATA_W-1:0] b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [N*N*ACC_W-1:0]  res_o
);

    localparam int unsigned T_W = cnt_width(N);
    localparam logic [T_W-1:0] T_LAST = T_W'(3 * N - 3);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   pe_en;

    logic [T_W-1:0]        t;
    logic [N*N*DATA_W-1:0] a_q;
    logic [N*N*DATA_W-1:0] b_q;

    logic [DATA_W-1:0] a_edge [N];
    logic [DATA_W-1:0] b_edge [N];
    logic [DATA_W-1:0] a_h [N][N+1];
    logic [DATA_W-1:0] b_v [N+1][N];
    logic [ACC_W-1:0]  acc [N][N];
    logic [N*N*ACC_W-1:0] acc_flat;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    accept    = 1'b1;
                    state_nxt = FEED;
                end
            end
            FEED:    if (t == T_LAST) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign pe_en = (state == FEED) || (state == FLUSH);

    // ---------------- operand latch, counter, outputs ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q    <= '0;
            b_q    <= '0;
            t      <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            res_o  <= '0;
        end else begin
            done_o <= 1'b0;
            if (accept) begin
                a_q    <= a_i;
                b_q    <= b_i;
                t      <= '0;
                busy_o <= 1'b1;
            end
            if (state == FEED) t <= t + 1'b1;
            if (state == DONE) begin
                busy_o <= 1'b0;
                done_o <= 1'b1;
                res_o  <= acc_flat;
            end
        end
    end

    // ---------------- edge skew ----------------
    // Row r gets A[r][t-r], column c gets B[t-c][c]; zero outside FEED or
    // when the index falls off the matrix.
    always_comb begin
        for (int unsigned l = 0; l < N; l++) begin
            int idx;
            idx       = skew_idx(32'(t), l);
            a_edge[l] = '0;
            b_edge[l] = '0;
            if ((state == FEED) && idx_valid(idx, N)) begin
                a_edge[l] = a_q[(int'(l) * int'(N) + idx) * int'(DATA_W) +: DATA_W];
                b_edge[l] = b_q[(idx * int'(N) + int'(l)) * int'(DATA_W) +: DATA_W];
            end
        end
    end

    // ---------------- PE array ----------------
    for (genvar r = 0; r < N; r++) begin : g_row
        assign a_h[r][0] = a_edge[r];
        assign b_v[0][r] = b_edge[r];
        for (genvar c = 0; c < N; c++) begin : g_col
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .clr_i  (accept),
                .en_i   (pe_en),
                .a_i    (a_h[r][c]),
                .b_i    (b_v[r][c]),
                .a_o    (a_h[r][c+1]),
                .b_o    (b_v[r+1][c]),
                .acc_o  (acc[r][c])
            );
            assign acc_flat[(r*N+c)*ACC_W +: ACC_W] = acc[r][c];
        end
    end

endmodule

// File: tb/tb_systolic_mm_core.sv
// tb_systolic_mm_core: directed and randomized bench for systolic_mm_core.
// Two instances: N=4/DATA_W=32 and N=2/DATA_W=8. Expected matrices come from
// a plain triple-loop matrix product in 128-bit arithmetic.
module tb_systolic_mm_core;

    localparam int N4 = 4, DW4 = 32, AW4 = 66;
    localparam int N2 = 2, DW2 = 8,  AW2 = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst4, start4, busy4, done4;
    logic [N4*N4*DW4-1:0]  a4, b4;
    logic [N4*N4*AW4-1:0]  res4;
    logic                  rst2, start2, busy2, done2;
    logic [N2*N2*DW2-1:0]  a2, b2;
    logic [N2*N2*AW2-1:0]  res2;

    int vectors = 0;
    int miscompares = 0;

    systolic_mm_core #(.N(N4), .DATA_W(DW4)) dut4 (
        .clk_i(clk), .rst_ni(rst4), .start_i(start4), .a_i(a4), .b_i(b4),
        .busy_o(busy4), .done_o(done4), .res_o(res4)
    );

    systolic_mm_core #(.N(N2), .DATA_W(DW2)) dut2 (
        .clk_i(clk), .rst_ni(rst2), .start_i(start2), .a_i(a2), .b_i(b2),
        .busy_o(busy2), .done_o(done2), .res_o(res2)
    );

    // ---------------- reference model ----------------
    function automatic logic [127:0] lomask(input int w);
        return (128'd1 << w) - 128'd1;
    endfunction

    function automatic logic [127:0] elem(input logic [511:0] v, input int idx, input int dw);
        logic [127:0] e;
        e = 128'(v >> (idx * dw)) & lomask(dw);
`ifdef SYSTOLIC_SIGNED_EN
        if (e[dw-1]) e = e | ~lomask(dw);
`endif
        return e;
    endfunction

    function automatic logic [127:0] mm_elem(input logic [511:0] a, input logic [511:0] b,
                                             input int n, input int dw, input int aw,
                                             input int r, input int c);
        logic [127:0] sum = '0;
        for (int k = 0; k < n; k++)
            sum = sum + elem(a, r*n+k, dw) * elem(b, k*n+c, dw);
        return sum & lomask(aw);
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res4(input string tag, input logic [511:0] a, input logic [511:0] b);
        for (int r = 0; r < N4; r++)
            for (int c = 0; c < N4; c++)
                chk($sformatf("%s_c%0d%0d", tag, r, c),
                    128'(res4 >> ((r*N4+c)*AW4)) & lomask(AW4),
                    mm_elem(a, b, N4, DW4, AW4, r, c));
    endtask

    task automatic chk_res2(input string tag, input logic [511:0] a, input logic [511:0] b);
        for (int r = 0; r < N2; r++)
            for (int c = 0; c < N2; c++)
                chk($sformatf("%s_c%0d%0d", tag, r, c),
                    128'(res2 >> ((r*N2+c)*AW2)) & lomask(AW2),
                    mm_elem(a, b, N2, DW2, AW2, r, c));
    endtask

    // Pulse start for one cycle; return the number of edges from E0 to done.
    task automatic go4(input logic [511:0] a, input logic [511:0] b, output int edges);
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("busy4_accept", 128'(busy4), 128'(1));
        edges = 0;
        while (!done4 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic go2(input logic [31:0] a, input logic [31:0] b, output int edges);
        @(negedge clk);
        a2 = a; b2 = b; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        edges = 0;
        while (!done2 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [511:0] ma, mb, ma2, mb2;
        int edges, dones;

        rst4 = 1'b0; rst2 = 1'b0; start4 = 1'b0; start2 = 1'b0;
        a4 = '0; b4 = '0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy4", 128'(busy4), 128'(0));
        chk("rst_done4", 128'(done4), 128'(0));
        chk("rst_res4",  128'(|res4), 128'(0));
        chk("rst_busy2", 128'(busy2), 128'(0));
        @(negedge clk);
        rst4 = 1'b1; rst2 = 1'b1;

        // 1: identity x B
        ma = '0; mb = '0;
        for (int r = 0; r < N4; r++) ma[(r*N4+r)*DW4 +: DW4] = 32'd1;
        for (int k = 0; k < N4; k++)
            for (int c = 0; c < N4; c++) mb[(k*N4+c)*DW4 +: DW4] = 32'(4*k + c + 1);
        go4(ma, mb, edges);
        chk("t1_latency", 128'(edges), 128'(3*N4));
        chk("t1_done", 128'(done4), 128'(1));
        chk("t1_busy_low", 128'(busy4), 128'(0));
        chk("t1_c00_is_b", 128'(res4[0 +: AW4]), 128'(1));
        chk("t1_c33_is_b", 128'(res4[15*AW4 +: AW4]), 128'(16));
        chk_res4("t1", ma, mb);
        @(posedge clk); #1;
        chk("t1_done_pulse", 128'(done4), 128'(0));
        repeat (3) @(posedge clk);
        #1;
        chk_res4("t1_hold", ma, mb);

        // 2: all ones (max magnitude)
        ma = '0; mb = '0;
        ma[N4*N4*DW4-1:0] = '1; mb[N4*N4*DW4-1:0] = '1;
        go4(ma, mb, edges);
        chk("t2_latency", 128'(edges), 128'(3*N4));
        chk_res4("t2", ma, mb);

        // 3: A all -1, B all 3
        mb = '0;
        for (int i = 0; i < N4*N4; i++) mb[i*DW4 +: DW4] = 32'd3;
        go4(ma, mb, edges);
        chk_res4("t3", ma, mb);

        // 4: start held high; operands changed mid-run
        for (int i = 0; i < 16; i++) begin
            ma[i*DW4 +: DW4] = $urandom(); mb[i*DW4 +: DW4] = $urandom();
            ma2[i*DW4 +: DW4] = $urandom(); mb2[i*DW4 +: DW4] = $urandom();
        end
        @(negedge clk);
        a4 = ma[N4*N4*DW4-1:0]; b4 = mb[N4*N4*DW4-1:0]; start4 = 1'b1;
        @(posedge clk); #1;
        a4 = ma2[N4*N4*DW4-1:0]; b4 = mb2[N4*N4*DW4-1:0];
        edges = 0;
        while (!done4 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("t4_latency", 128'(edges), 128'(3*N4));
        chk_res4("t4_first", ma, mb);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!done4 && edges < 40);
        start4 = 1'b0;
        chk("t4_period", 128'(edges), 128'(3*N4+1));
        chk_res4("t4_second", ma2, mb2);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_idle_after", 128'(busy4), 128'(0));

        // 5: reset in the middle of a run
        @(negedge clk);
        a4 = ma[N4*N4*DW4-1:0]; b4 = mb[N4*N4*DW4-1:0]; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst4 = 1'b0;
        #1;
        chk("t5_busy", 128'(busy4), 128'(0));
        chk("t5_done", 128'(done4), 128'(0));
        chk("t5_res",  128'(|res4), 128'(0));
        @(negedge clk);
        rst4 = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done4) dones++;
        end
        chk("t5_no_done", 128'(dones), 128'(0));
        go4(ma2, mb2, edges);
        chk("t5_latency", 128'(edges), 128'(3*N4));
        chk_res4("t5_fresh", ma2, mb2);

        // 6: N=2, DATA_W=8 random runs (first run is the all-ones corner)
        for (int run = 0; run < 200; run++) begin
            logic [31:0] ra, rb;
            ra = (run == 0) ? 32'hFFFF_FFFF : $urandom();
            rb = (run == 0) ? 32'hFFFF_FFFF : $urandom();
            go2(ra, rb, edges);
            chk("t6_latency", 128'(edges), 128'(3*N2));
            chk_res2("t6", 512'(ra), 512'(rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
